// File: rtl/hyperbus_pwr_seq.sv
// Power/reset sequencer for the HyperBus domain: drives AXI isolation, clock gate and
// subsystem reset so the domain can be brought up, shut down or soft-reset safely.
module hyperbus_pwr_seq #(
    parameter int RstHoldCycles = 16,
    parameter int StartupCycles = 60000,
    parameter int IsoTimeout    = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       sw_rst_i,
    input  logic       axi_isolated_i,
    output logic       axi_isolate_o,
    output logic       clk_en_o,
    output logic       hyper_rst_no,
    output logic       ready_o,
    output logic       err_timeout_o,
    output logic [2:0] state_o
);

    localparam int MaxA      = (RstHoldCycles > StartupCycles) ? RstHoldCycles : StartupCycles;
    localparam int MaxCycles = (MaxA > IsoTimeout) ? MaxA : IsoTimeout;
    localparam int CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [CntWidth-1:0] RstLast     = CntWidth'(RstHoldCycles - 1);
    localparam logic [CntWidth-1:0] StartupLast = CntWidth'(StartupCycles - 1);
    localparam logic [CntWidth-1:0] IsoLast     = CntWidth'(IsoTimeout - 1);

    if (RstHoldCycles < 1) begin : gen_bad_rst_hold
        $error("RstHoldCycles must be >= 1");
    end
    if (StartupCycles < 1) begin : gen_bad_startup
        $error("StartupCycles must be >= 1");
    end
    if (IsoTimeout < 1) begin : gen_bad_iso_timeout
        $error("IsoTimeout must be >= 1");
    end

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StRst     = 3'd1,
        StStartup = 3'd2,
        StDeiso   = 3'd3,
        StOn      = 3'd4,
        StIso     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q;
    logic                err_q, err_d;
    logic [3:0]          out_d;  // {iso, clk_en, rst_n, ready} for the next state
    logic                timed_d;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            StOff:     if (en_i) state_d = StRst;
            StRst:     if (cnt_q == RstLast) state_d = en_i ? StStartup : StOff;
            StStartup: if (cnt_q == StartupLast) state_d = StDeiso;
            StDeiso:   if (!axi_isolated_i) state_d = StOn;
            StOn: begin
                if (!en_i || sw_rst_i) begin
                    state_d = StIso;
                    err_d   = 1'b0;
                end
            end
            StIso: begin
                // A late isolation ack on the timeout cycle still counts as a clean exit.
                if (axi_isolated_i) begin
                    state_d = StRst;
                end else if (cnt_q == IsoLast) begin
                    state_d = StRst;
                    err_d   = 1'b1;
                end
            end
            default:   state_d = StOff;
        endcase
    end

    always_comb begin
        out_d   = 4'b1000;
        timed_d = 1'b0;
        case (state_d)
            StOff:     out_d = 4'b1000;
            StRst:     begin out_d = 4'b1100; timed_d = 1'b1; end
            StStartup: begin out_d = 4'b1110; timed_d = 1'b1; end
            StDeiso:   out_d = 4'b0110;
            StOn:      out_d = 4'b0111;
            StIso:     begin out_d = 4'b1110; timed_d = 1'b1; end
            default:   out_d = 4'b1000;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StOff;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            axi_isolate_o <= 1'b1;
            clk_en_o      <= 1'b0;
            hyper_rst_no  <= 1'b0;
            ready_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_d != state_q || !timed_d) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
            {axi_isolate_o, clk_en_o, hyper_rst_no, ready_o} <= out_d;
        end
    end

    assign err_timeout_o = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_hyperbus_pwr_seq.sv
// Directed bench for hyperbus_pwr_seq with a small AXI isolate-stage model (lagged ack).
module tb_hyperbus_pwr_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sw_rst = 1'b0;
    logic       isolated = 1'b1;
    logic       iso, clk_en, rst_n, ready, err;
    logic [2:0] state;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         lag = 2;
    logic       stuck = 1'b0;
    logic [7:0] hist = 8'hFF;
    logic       clk_low_seen = 1'b0;

    hyperbus_pwr_seq #(
        .RstHoldCycles(4),
        .StartupCycles(8),
        .IsoTimeout   (16)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .sw_rst_i      (sw_rst),
        .axi_isolated_i(isolated),
        .axi_isolate_o (iso),
        .clk_en_o      (clk_en),
        .hyper_rst_no  (rst_n),
        .ready_o       (ready),
        .err_timeout_o (err),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    // hist[k] holds axi_isolate_o from k cycles ago; isolation ack lags the request.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        hist = {hist[6:0], iso};
        isolated = stuck ? 1'b0 : hist[lag];
        if (!clk_en) clk_low_seen = 1'b1;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s @cyc%0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_iso"}, int'(iso), 1);
        chk({tag, "_clk_en"}, int'(clk_en), 0);
        chk({tag, "_rst_n"}, int'(rst_n), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        // Reset
        step();
        step();
        chk_reset_outputs("rst");
        rst = 1'b0;
        en  = 1'b1;
        cyc = 0;

        // 1 Power-up
        chk("pu_state0", int'(state), 0);
        chk("pu_clk_en0", int'(clk_en), 0);
        run_to(1);
        chk("pu_clk_en1", int'(clk_en), 1);
        chk("pu_state1", int'(state), 1);
        run_to(4);
        chk("pu_rst_n4", int'(rst_n), 0);
        run_to(5);
        chk("pu_rst_n5", int'(rst_n), 1);
        chk("pu_state5", int'(state), 2);
        run_to(12);
        chk("pu_iso12", int'(iso), 1);
        run_to(13);
        chk("pu_iso13", int'(iso), 0);
        chk("pu_state13", int'(state), 3);
        run_to(15);
        chk("pu_ready15", int'(ready), 0);
        run_to(16);
        chk("pu_ready16", int'(ready), 1);
        chk("pu_state16", int'(state), 4);

        // 2 Shutdown, ack 3 cycles after request
        run_to(18);
        lag = 3;
        en  = 1'b0;
        run_to(19);
        chk("sd_state19", int'(state), 5);
        chk("sd_iso19", int'(iso), 1);
        chk("sd_ready19", int'(ready), 0);
        run_to(22);
        chk("sd_state22", int'(state), 5);
        run_to(23);
        chk("sd_state23", int'(state), 1);
        chk("sd_rst_n23", int'(rst_n), 0);
        run_to(26);
        chk("sd_state26", int'(state), 1);
        chk("sd_clk_en26", int'(clk_en), 1);
        run_to(27);
        chk("sd_state27", int'(state), 0);
        chk("sd_clk_en27", int'(clk_en), 0);
        chk("sd_err27", int'(err), 0);

        // 3 Timeout with isolation stuck low
        lag = 2;
        en  = 1'b1;
        run_to(43);
        chk("to_state43", int'(state), 4);
        stuck = 1'b1;
        en    = 1'b0;
        run_to(44);
        chk("to_state44", int'(state), 5);
        run_to(59);
        chk("to_state59", int'(state), 5);
        chk("to_err59", int'(err), 0);
        run_to(60);
        chk("to_state60", int'(state), 1);
        chk("to_err60", int'(err), 1);
        run_to(64);
        chk("to_state64", int'(state), 0);
        chk("to_err64", int'(err), 1);
        run_to(70);
        chk("to_err70", int'(err), 1);
        stuck = 1'b0;
        en    = 1'b1;
        run_to(86);
        chk("to_state86", int'(state), 4);
        chk("to_err86", int'(err), 1);

        // 4 Soft reset, with an ignored pulse during STARTUP
        clk_low_seen = 1'b0;
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        chk("sr_state87", int'(state), 5);
        chk("sr_err87", int'(err), 0);
        run_to(90);
        chk("sr_state90", int'(state), 1);
        run_to(94);
        chk("sr_state94", int'(state), 2);
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
        chk("sr_state95", int'(state), 2);
        run_to(101);
        chk("sr_state101", int'(state), 2);
        run_to(102);
        chk("sr_state102", int'(state), 3);
        run_to(104);
        chk("sr_state104", int'(state), 3);
        run_to(105);
        chk("sr_state105", int'(state), 4);
        chk("sr_ready105", int'(ready), 1);
        chk("sr_clk_low", int'(clk_low_seen), 0);

        // 5 Async reset mid-STARTUP (cnt=5)
        rst = 1'b1;
        #1;
        rst = 1'b0;
        cyc = 0;
        run_to(10);
        chk("ar_state10", int'(state), 2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("ar");
        #1;
        rst = 1'b0;
        cyc = 0;
        run_to(4);
        chk("ar_state4", int'(state), 1);
        run_to(5);
        chk("ar_state5", int'(state), 2);
        run_to(12);
        chk("ar_state12", int'(state), 2);

        // 6 Deferred off: en drops on the last STARTUP cycle
        en = 1'b0;
        run_to(13);
        chk("df_state13", int'(state), 3);
        chk("df_iso13", int'(iso), 0);
        run_to(16);
        chk("df_state16", int'(state), 4);
        chk("df_ready16", int'(ready), 1);
        run_to(17);
        chk("df_state17", int'(state), 5);
        chk("df_iso17", int'(iso), 1);
        run_to(24);
        chk("df_state24", int'(state), 0);
        chk("df_clk_en24", int'(clk_en), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
